// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared byte width and transmit sequencer state encodings
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/tx_fifo_mem_module.sv
// rtl/tx_fifo_mem_module.sv - DEPTH x DATA_W register array, sync write, async read
import uart_pkg::*;

module tx_fifo_mem_module #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tx_fifo_feed_module.sv
// rtl/tx_fifo_feed_module.sv - byte FIFO feeding tx_module through the TX_En/TX_Done handshake
import uart_pkg::*;

module tx_fifo_feed_module #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Wr_En,
    input  logic [DATA_W-1:0] Wr_Data,
    output logic              Full,
    output logic              Empty,
    output logic [ADDR_W:0]   Count,
    output logic              Overflow_Sig,
    input  logic              TX_Done_Sig,
    output logic              TX_En_Sig,
    output logic [DATA_W-1:0] TX_Data
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   count_next;
    logic              wr_ok;
    logic              pop;
    state_t            state;
    state_t            state_next;

    // Registered Full gates writes, so a pop in the same cycle cannot free a slot early.
    assign wr_ok = Wr_En && !Full;
    assign pop   = (state == ST_LOAD);

    tx_fifo_mem_module #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (CLK),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (Wr_Data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_comb begin
        count_next = Count;
        case ({wr_ok, pop})
            2'b10:   count_next = Count + (ADDR_W+1)'(1);
            2'b01:   count_next = Count - (ADDR_W+1)'(1);
            default: count_next = Count;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (!Empty) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_SEND;
            ST_SEND: if (TX_Done_Sig) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            Count        <= '0;
            Full         <= 1'b0;
            Empty        <= 1'b1;
            Overflow_Sig <= 1'b0;
            TX_En_Sig    <= 1'b0;
            TX_Data      <= '0;
            state        <= ST_IDLE;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + ADDR_W'(1);
                TX_Data <= rd_data;
            end
            Count        <= count_next;
            Full         <= (count_next == FULL_CNT);
            Empty        <= (count_next == '0);
            Overflow_Sig <= Wr_En && Full;
            TX_En_Sig    <= (state_next == ST_SEND);
            state        <= state_next;
        end
    end

endmodule
